// File: rtl/ghash_scheduler.sv
// ghash_scheduler
//   Sequences one GCM instance into a GHASH stage: accumulator clear, AAD
//   blocks, ciphertext blocks, then the final length block.
//
//   Ports
//     clk                          sole clock, rising edge
//     i_rst_n                      synchronous active-low reset
//     i_start                      new instance request (honoured in IDLE only)
//     i_aad_blocks / i_ct_blocks   block counts, captured on accepted start
//     i_aad_valid / i_aad          AAD block offer
//     i_ct_valid / i_cipher_text   ciphertext block offer
//     i_abort                      abort instance (only with GHASH_SCHED_ABORT_EN)
//     o_aad_ready / o_ct_ready     handshake readies
//     o_aad / o_cipher_text        registered blocks to GHASH
//     o_phase                      00 idle/clear, 10 AAD, 01 CT, 11 length
//     o_new_instance               one-cycle accumulator clear
//     o_busy / o_done              instance active / length block issued
//
//   Build option: define GHASH_SCHED_ABORT_EN to add the i_abort port.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for i_start
//   CLEAR | one cycle, issues accumulator clear
//   AAD   | accepting AAD blocks until the AAD count is exhausted
//   CT    | accepting ciphertext blocks until the CT count is exhausted
//   LEN   | issues the {aad_bits, ct_bits} length block and o_done
//
//   All GHASH-side outputs are registered: the value a state issues appears
//   the cycle after the edge on which that state executes.
module ghash_scheduler (
   input  logic          clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic [15:0]   i_aad_blocks,
   input  logic [15:0]   i_ct_blocks,
   input  logic          i_aad_valid,
   input  logic [0:127]  i_aad,
   input  logic          i_ct_valid,
   input  logic [0:127]  i_cipher_text,
`ifdef GHASH_SCHED_ABORT_EN
   input  logic          i_abort,
`endif
   output logic          o_aad_ready,
   output logic          o_ct_ready,
   output logic [0:127]  o_aad,
   output logic [0:127]  o_cipher_text,
   output logic [0:1]    o_phase,
   output logic          o_new_instance,
   output logic          o_busy,
   output logic          o_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_AAD   = 3'd2;
   localparam logic [2:0] S_CT    = 3'd3;
   localparam logic [2:0] S_LEN   = 3'd4;

   logic [2:0]   state_q, state_d;
   logic [15:0]  aad_tot_q, aad_tot_d, ct_tot_q, ct_tot_d;
   logic [15:0]  aad_rem_q, aad_rem_d, ct_rem_q, ct_rem_d;
   logic [0:127] aad_q, aad_d, ct_q, ct_d;
   logic [0:1]   phase_q, phase_d;
   logic         new_inst_q, new_inst_d;
   logic         done_q, done_d;
   logic         abort_w;
   logic [63:0]  aad_bits, ct_bits;

`ifdef GHASH_SCHED_ABORT_EN
   assign abort_w = i_abort;
`else
   assign abort_w = 1'b0;
`endif

   // Abort wins over a transfer, so ready is withdrawn in the abort cycle.
   assign o_aad_ready = (state_q == S_AAD) && !abort_w;
   assign o_ct_ready  = (state_q == S_CT)  && !abort_w;
   assign o_busy      = (state_q != S_IDLE);

   // Widen before shifting so 16-bit counts cannot overflow.
   assign aad_bits = {48'd0, aad_tot_q} << 7;
   assign ct_bits  = {48'd0, ct_tot_q} << 7;

   always_comb begin
      state_d    = state_q;
      aad_tot_d  = aad_tot_q;
      ct_tot_d   = ct_tot_q;
      aad_rem_d  = aad_rem_q;
      ct_rem_d   = ct_rem_q;
      aad_d      = aad_q;
      ct_d       = ct_q;
      phase_d    = 2'b00;
      new_inst_d = 1'b0;
      done_d     = 1'b0;
      if (abort_w && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  aad_tot_d = i_aad_blocks;
                  ct_tot_d  = i_ct_blocks;
                  aad_rem_d = i_aad_blocks;
                  ct_rem_d  = i_ct_blocks;
                  state_d   = S_CLEAR;
               end
            end
            S_CLEAR: begin
               new_inst_d = 1'b1;
               if (aad_rem_q != 16'd0)     state_d = S_AAD;
               else if (ct_rem_q != 16'd0) state_d = S_CT;
               else                        state_d = S_LEN;
            end
            S_AAD: begin
               if (i_aad_valid) begin
                  aad_d     = i_aad;
                  phase_d   = 2'b10;
                  aad_rem_d = aad_rem_q - 16'd1;
                  if (aad_rem_q == 16'd1)
                     state_d = (ct_rem_q != 16'd0) ? S_CT : S_LEN;
               end
            end
            S_CT: begin
               if (i_ct_valid) begin
                  ct_d     = i_cipher_text;
                  phase_d  = 2'b01;
                  ct_rem_d = ct_rem_q - 16'd1;
                  if (ct_rem_q == 16'd1) state_d = S_LEN;
               end
            end
            S_LEN: begin
               ct_d    = {aad_bits, ct_bits};
               phase_d = 2'b11;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         aad_tot_q  <= 16'd0;
         ct_tot_q   <= 16'd0;
         aad_rem_q  <= 16'd0;
         ct_rem_q   <= 16'd0;
         aad_q      <= '0;
         ct_q       <= '0;
         phase_q    <= 2'b00;
         new_inst_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         aad_tot_q  <= aad_tot_d;
         ct_tot_q   <= ct_tot_d;
         aad_rem_q  <= aad_rem_d;
         ct_rem_q   <= ct_rem_d;
         aad_q      <= aad_d;
         ct_q       <= ct_d;
         phase_q    <= phase_d;
         new_inst_q <= new_inst_d;
         done_q     <= done_d;
      end
   end

   assign o_aad          = aad_q;
   assign o_cipher_text  = ct_q;
   assign o_phase        = phase_q;
   assign o_new_instance = new_inst_q;
   assign o_done         = done_q;

endmodule

// File: tb/tb_ghash_scheduler.sv
// Directed bench for ghash_scheduler: a table of instances with hand-computed
// length blocks and latencies, plus sequences for stalls, reset, restart
// attempts and (when built with GHASH_SCHED_ABORT_EN) abort.
// "Cycle k" below is the cycle following the k-th rising edge after the
// edge that accepted i_start.
module tb_ghash_scheduler;
   logic         clk = 1'b0;
   logic         i_rst_n, i_start, i_aad_valid, i_ct_valid;
   logic [15:0]  i_aad_blocks, i_ct_blocks;
   logic [0:127] i_aad, i_cipher_text;
   logic         o_aad_ready, o_ct_ready, o_new_instance, o_busy, o_done;
   logic [0:127] o_aad, o_cipher_text;
   logic [0:1]   o_phase;
`ifdef GHASH_SCHED_ABORT_EN
   logic         i_abort;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ghash_scheduler dut (
      .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .i_aad_blocks(i_aad_blocks), .i_ct_blocks(i_ct_blocks),
      .i_aad_valid(i_aad_valid), .i_aad(i_aad),
      .i_ct_valid(i_ct_valid), .i_cipher_text(i_cipher_text),
`ifdef GHASH_SCHED_ABORT_EN
      .i_abort(i_abort),
`endif
      .o_aad_ready(o_aad_ready), .o_ct_ready(o_ct_ready),
      .o_aad(o_aad), .o_cipher_text(o_cipher_text), .o_phase(o_phase),
      .o_new_instance(o_new_instance), .o_busy(o_busy), .o_done(o_done)
   );

   typedef struct {
      logic [15:0]  aad;
      logic [15:0]  ct;
      logic [127:0] len;
      int           lat;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] aw(input int i);
      return {32'hAAD0_0000, 32'(i), 32'h0123_4567, ~32'(i)};
   endfunction

   function automatic logic [127:0] cw(input int i);
      return {32'hC1F0_0000, ~32'(i), 32'h89AB_CDEF, 32'(i)};
   endfunction

   task automatic run_inst(input logic [15:0] a, input logic [15:0] c,
                           input logic [127:0] exp_len, input int lat);
      int na, nc, ci;
      logic [1:0] ep;
      na = int'(a);
      nc = int'(c);
      i_aad_blocks = a;
      i_ct_blocks  = c;
      i_start      = 1'b1;
      i_aad_valid  = 1'b1;
      i_ct_valid   = 1'b1;
      i_aad        = aw(0);
      i_cipher_text = cw(0);
      tick();
      i_start = 1'b0;
      chk("busy_after_start", 128'(o_busy), 128'(1'b1));
      for (int k = 1; k <= lat; k++) begin
         tick();
         if (k == 1)                ep = 2'b00;
         else if (k <= na + 1)      ep = 2'b10;
         else if (k <= na + nc + 1) ep = 2'b01;
         else                       ep = 2'b11;
         chk("phase", 128'(o_phase), 128'(ep));
         chk("done", 128'(o_done), 128'(k == lat));
         chk("new_instance", 128'(o_new_instance), 128'(k == 1));
         chk("busy", 128'(o_busy), 128'(k < lat));
         chk("aad_ready", 128'(o_aad_ready), 128'(k <= na));
         chk("ct_ready", 128'(o_ct_ready), 128'(k > na && k <= na + nc));
         if (ep == 2'b10) chk("aad_data", 128'(o_aad), aw(k - 2));
         if (ep == 2'b01) chk("ct_data", 128'(o_cipher_text), cw(k - 2 - na));
         if (ep == 2'b11) chk("len_block", 128'(o_cipher_text), exp_len);
         i_aad = aw(k - 1);
         ci = k - 1 - na;
         i_cipher_text = cw(ci < 0 ? 0 : ci);
      end
      i_aad_valid = 1'b0;
      i_ct_valid  = 1'b0;
      tick();
      chk("done_pulse_ends", 128'(o_done), 128'(1'b0));
   endtask

   initial begin
      vec_t vecs[6];
      int   done_at, done_cnt;
      logic [127:0] len_seen;
      logic [127:0] aad_before;

      vecs[0] = '{16'd1,   16'd2,   128'h0000000000000080_0000000000000100, 5};
      vecs[1] = '{16'd0,   16'd0,   128'h0000000000000000_0000000000000000, 2};
      vecs[2] = '{16'd3,   16'd0,   128'h0000000000000180_0000000000000000, 5};
      vecs[3] = '{16'd0,   16'd1,   128'h0000000000000000_0000000000000080, 3};
      vecs[4] = '{16'd2,   16'd5,   128'h0000000000000100_0000000000000280, 9};
      vecs[5] = '{16'd512, 16'd600, 128'h0000000000010000_0000000000012C00, 1114};

      i_rst_n = 1'b0; i_start = 1'b0; i_aad_blocks = '0; i_ct_blocks = '0;
      i_aad_valid = 1'b0; i_ct_valid = 1'b0; i_aad = '0; i_cipher_text = '0;
`ifdef GHASH_SCHED_ABORT_EN
      i_abort = 1'b0;
`endif
      tick();
      tick();
      chk("rst_phase", 128'(o_phase), 128'(2'b00));
      chk("rst_busy", 128'(o_busy), 128'(1'b0));
      chk("rst_done", 128'(o_done), 128'(1'b0));
      chk("rst_new_inst", 128'(o_new_instance), 128'(1'b0));
      chk("rst_readies", 128'({o_aad_ready, o_ct_ready}), 128'(2'b00));
      chk("rst_aad", 128'(o_aad), 128'(0));
      chk("rst_ct", 128'(o_cipher_text), 128'(0));
      i_rst_n = 1'b1;
      tick();

      for (int v = 0; v < 6; v++)
         run_inst(vecs[v].aad, vecs[v].ct, vecs[v].len, vecs[v].lat);

      // AAD=2, CT=0 with a one-cycle valid gap.
      i_aad_blocks = 16'd2; i_ct_blocks = 16'd0; i_start = 1'b1;
      i_aad_valid = 1'b1; i_aad = aw(0);
      tick();
      i_start = 1'b0;
      tick();
      chk("gap_new_inst", 128'(o_new_instance), 128'(1'b1));
      tick();
      chk("gap_phase1", 128'(o_phase), 128'(2'b10));
      chk("gap_aad1", 128'(o_aad), aw(0));
      i_aad_valid = 1'b0; i_aad = aw(9);
      tick();
      chk("gap_phase_idle", 128'(o_phase), 128'(2'b00));
      chk("gap_aad_hold", 128'(o_aad), aw(0));
      chk("gap_ready_held", 128'(o_aad_ready), 128'(1'b1));
      i_aad_valid = 1'b1; i_aad = aw(1);
      tick();
      chk("gap_phase2", 128'(o_phase), 128'(2'b10));
      chk("gap_aad2", 128'(o_aad), aw(1));
      i_aad_valid = 1'b0;
      tick();
      chk("gap_len_phase", 128'(o_phase), 128'(2'b11));
      chk("gap_len", 128'(o_cipher_text), 128'h0000000000000100_0000000000000000);
      chk("gap_done", 128'(o_done), 128'(1'b1));
      tick();

      // Reset during CT of a 4-block instance.
      i_aad_blocks = 16'd0; i_ct_blocks = 16'd4; i_start = 1'b1;
      i_ct_valid = 1'b1; i_cipher_text = cw(0);
      tick();
      i_start = 1'b0;
      tick();
      tick();
      i_cipher_text = cw(1);
      tick();
      chk("pre_rst_phase", 128'(o_phase), 128'(2'b01));
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      chk("midrst_phase", 128'(o_phase), 128'(2'b00));
      chk("midrst_ct", 128'(o_cipher_text), 128'(0));
      chk("midrst_aad", 128'(o_aad), 128'(0));
      chk("midrst_flags", 128'({o_busy, o_done, o_new_instance, o_aad_ready, o_ct_ready}), 128'(5'b0));
      done_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (o_done) done_cnt++;
      end
      chk("midrst_no_done", 128'(done_cnt), 128'(0));
      i_ct_valid = 1'b0;
      run_inst(16'd0, 16'd1, 128'h0000000000000000_0000000000000080, 3);

      // i_start held high with different counts while busy.
      i_aad_blocks = 16'd1; i_ct_blocks = 16'd2; i_start = 1'b1;
      i_aad_valid = 1'b1; i_ct_valid = 1'b1;
      tick();
      i_aad_blocks = 16'd5; i_ct_blocks = 16'd7;
      done_at = -1; len_seen = '0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (o_done && done_at < 0) begin
            done_at  = k;
            len_seen = o_cipher_text;
            i_start  = 1'b0;
         end
      end
      i_start = 1'b0;
      chk("restart_done_cycle", 128'(done_at), 128'(5));
      chk("restart_len", len_seen, 128'h0000000000000080_0000000000000100);
      i_aad_valid = 1'b0; i_ct_valid = 1'b0;
      tick();

`ifdef GHASH_SCHED_ABORT_EN
      // Abort while an AAD block is offered.
      aad_before = o_aad;
      i_aad_blocks = 16'd3; i_ct_blocks = 16'd1; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      i_aad_valid = 1'b1; i_aad = aw(77); i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("abort_phase", 128'(o_phase), 128'(2'b00));
      chk("abort_aad_hold", 128'(o_aad), aad_before);
      chk("abort_idle", 128'({o_busy, o_aad_ready, o_ct_ready, o_done}), 128'(4'b0));
      done_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (o_done) done_cnt++;
      end
      chk("abort_no_done", 128'(done_cnt), 128'(0));
      i_aad_valid = 1'b0;
`else
      aad_before = '0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
